// File: rtl/ysyx_24100027_pkg.sv
// Shared encodings for the NPC execute stage: ALU ops, control-transfer kinds,
// operand-B selects and branch funct3 codes.
package ysyx_24100027_pkg;

    localparam int unsigned XLEN_W   = 32;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned BR_W     = 2;
    localparam int unsigned BSEL_W   = 2;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned RD_W     = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'b1101;
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'b0111;

    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_COND = 2'b01;
    localparam logic [BR_W-1:0] BR_JAL  = 2'b10;
    localparam logic [BR_W-1:0] BR_JALR = 2'b11;

    localparam logic [BSEL_W-1:0] BSEL_RS2  = 2'b00;
    localparam logic [BSEL_W-1:0] BSEL_IMM  = 2'b01;
    localparam logic [BSEL_W-1:0] BSEL_FOUR = 2'b10;
    localparam logic [BSEL_W-1:0] BSEL_ZERO = 2'b11;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } exu_state_e;

    // Conditional-branch outcome from the ALU flags; unused funct3 codes never take.
    function automatic logic branch_cond(input logic [F3_W-1:0] f3,
                                         input logic zero,
                                         input logic less);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:           t = zero;
            F3_BNE:           t = !zero;
            F3_BLT, F3_BLTU:  t = less;
            F3_BGE, F3_BGEU:  t = !less;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ysyx_24100027_exu_alu.sv
// Combinational ALU for the execute stage; zero/less flags feed branch resolution.
module ysyx_24100027_ALU
    import ysyx_24100027_pkg::*;
(
    input  logic [XLEN_W-1:0]   a,
    input  logic [XLEN_W-1:0]   b,
    input  logic [ALU_OP_W-1:0] aluctr,
    output logic [XLEN_W-1:0]   result,
    output logic                zero,
    output logic                less
);

    logic               less_s;
    logic               less_u;
    logic [SHAMT_W-1:0] shamt;

    assign less_s = $signed(a) < $signed(b);
    assign less_u = a < b;
    assign shamt  = b[SHAMT_W-1:0];

    // Bit 3 of the op distinguishes the unsigned compare (sltu) from slt.
    assign less = aluctr[3] ? less_u : less_s;
    assign zero = (result == '0);

    always_comb begin
        result = '0;
        case (aluctr)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLT:   result = XLEN_W'(less_s);
            ALU_SLTU:  result = XLEN_W'(less_u);
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = XLEN_W'($signed(a) >>> shamt);
            ALU_PASSB: result = b;
            ALU_XOR:   result = a ^ b;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24100027_exu.sv
// NPC execute stage: operand select, ALU, branch/jump resolution, one-entry output register.
// Optional target-misalignment trap: YSYX_24100027_EXU_MISALIGN_EN.
module ysyx_24100027_exu
    import ysyx_24100027_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_rs1,
    input  logic [XLEN-1:0]     in_rs2,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [ALU_OP_W-1:0] in_aluctr,
    input  logic                in_asel,
    input  logic [BSEL_W-1:0]   in_bsel,
    input  logic [BR_W-1:0]     in_br,
    input  logic [F3_W-1:0]     in_funct3,
    input  logic [RD_W-1:0]     in_rd,
    input  logic                in_wen,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic [XLEN-1:0]     out_store,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_dnpc,
    output logic [RD_W-1:0]     out_rd,
    output logic                out_wen,
`ifdef YSYX_24100027_EXU_MISALIGN_EN
    output logic                out_exc,
`endif
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc
);

    exu_state_e      state_q;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            alu_less;
    logic [XLEN-1:0] tgt_base;
    logic [XLEN-1:0] tgt_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] dnpc;
    logic            taken;
    logic            accept;
    logic            redirect_ok;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    assign op_a = in_asel ? in_pc : in_rs1;

    always_comb begin
        op_b = in_rs2;
        case (in_bsel)
            BSEL_RS2:  op_b = in_rs2;
            BSEL_IMM:  op_b = in_imm;
            BSEL_FOUR: op_b = XLEN'(4);
            BSEL_ZERO: op_b = '0;
            default:   op_b = in_rs2;
        endcase
    end

    ysyx_24100027_ALU u_alu (
        .a      (op_a),
        .b      (op_b),
        .aluctr (in_aluctr),
        .result (alu_result),
        .zero   (alu_zero),
        .less   (alu_less)
    );

    // Dedicated target adder so the ALU stays free to produce the link value.
    assign tgt_base = (in_br == BR_JALR) ? in_rs1 : in_pc;
    assign tgt_sum  = tgt_base + in_imm;
    assign target   = (in_br == BR_JALR) ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;

    always_comb begin
        taken = 1'b0;
        case (in_br)
            BR_COND:         taken = branch_cond(in_funct3, alu_zero, alu_less);
            BR_JAL, BR_JALR: taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

    assign dnpc = taken ? target : in_pc + XLEN'(4);

`ifdef YSYX_24100027_EXU_MISALIGN_EN
    logic misalign;
    assign misalign    = taken && target[1];
    assign redirect_ok = taken && !misalign;
`else
    assign redirect_ok = taken;
`endif

    // Output entry: EMPTY/FULL plus captured payload; redirect pulses only on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            out_result     <= '0;
            out_store      <= '0;
            out_pc         <= '0;
            out_dnpc       <= '0;
            out_rd         <= '0;
            out_wen        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
`ifdef YSYX_24100027_EXU_MISALIGN_EN
            out_exc        <= 1'b0;
`endif
        end else begin
            redirect_valid <= 1'b0;
            if (accept) begin
                state_q        <= ST_FULL;
                out_result     <= alu_result;
                out_store      <= in_rs2;
                out_pc         <= in_pc;
                out_dnpc       <= dnpc;
                out_rd         <= in_rd;
                out_wen        <= in_wen;
                redirect_valid <= redirect_ok;
                redirect_pc    <= target;
`ifdef YSYX_24100027_EXU_MISALIGN_EN
                out_exc        <= misalign;
`endif
            end else if (out_ready) begin
                state_q <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100027_exu.sv
// Directed bench for the execute stage; each task drives one scenario and checks inline.
module tb_ysyx_24100027_exu;
    import ysyx_24100027_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [3:0]  in_aluctr;
    logic        in_asel;
    logic [1:0]  in_bsel;
    logic [1:0]  in_br;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_store, out_pc, out_dnpc;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef YSYX_24100027_EXU_MISALIGN_EN
    logic        out_exc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_24100027_exu #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .in_aluctr      (in_aluctr),
        .in_asel        (in_asel),
        .in_bsel        (in_bsel),
        .in_br          (in_br),
        .in_funct3      (in_funct3),
        .in_rd          (in_rd),
        .in_wen         (in_wen),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store      (out_store),
        .out_pc         (out_pc),
        .out_dnpc       (out_dnpc),
        .out_rd         (out_rd),
        .out_wen        (out_wen),
`ifdef YSYX_24100027_EXU_MISALIGN_EN
        .out_exc        (out_exc),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [3:0] ctr, input logic asel,
                          input logic [1:0] bsel, input logic [1:0] br, input logic [2:0] f3);
        in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_aluctr = ctr; in_asel = asel; in_bsel = bsel; in_br = br; in_funct3 = f3;
        in_rd = 5'd1; in_wen = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        set_op(32'h8000_0000, 32'h10, 32'h10, 32'h20, ALU_SUB, 1'b0, BSEL_RS2, BR_COND, F3_BEQ);
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b want 0", redirect_valid); end
        n_cmp++; if (out_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b want 0", out_wen); end
        n_cmp++; if ({out_result, out_dnpc, out_pc, out_store} !== 128'h0) begin n_err++; $display("FAIL reset_data: got %h %h %h %h want 0", out_result, out_dnpc, out_pc, out_store); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        set_op(32'h8000_0010, 32'd5, 32'd7, 32'h0, ALU_ADD, 1'b0, BSEL_RS2, BR_NONE, 3'b000);
        in_rd = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 32'd12) begin n_err++; $display("FAIL add_result: got %h want 0000000c", out_result); end
        n_cmp++; if (out_dnpc !== 32'h8000_0014) begin n_err++; $display("FAIL add_dnpc: got %h want 80000014", out_dnpc); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL add_redirect: got %b want 0", redirect_valid); end
        n_cmp++; if ({out_rd, out_wen, out_store, out_pc} !== {5'd3, 1'b1, 32'd7, 32'h8000_0010}) begin n_err++; $display("FAIL add_pass: got rd=%0d wen=%b st=%h pc=%h", out_rd, out_wen, out_store, out_pc); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_beq();
        set_op(32'h8000_0000, 32'h10, 32'h10, 32'h20, ALU_SUB, 1'b0, BSEL_RS2, BR_COND, F3_BEQ);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_redirect: got %b want 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h8000_0020) begin n_err++; $display("FAIL beq_target: got %h want 80000020", redirect_pc); end
        n_cmp++; if (out_dnpc !== 32'h8000_0020) begin n_err++; $display("FAIL beq_dnpc: got %h want 80000020", out_dnpc); end
        tick();
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_pulse_len: got %b want 0", redirect_valid); end
        // bne with equal operands falls through
        set_op(32'h8000_0200, 32'h10, 32'h10, 32'h20, ALU_SUB, 1'b0, BSEL_RS2, BR_COND, F3_BNE);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({redirect_valid, out_dnpc} !== {1'b0, 32'h8000_0204}) begin n_err++; $display("FAIL bne_not_taken: got rv=%b dnpc=%h want 0 80000204", redirect_valid, out_dnpc); end
    endtask

    task automatic test_blt();
        set_op(32'h8000_0100, 32'hFFFF_FFFF, 32'd1, 32'h40, ALU_SLT, 1'b0, BSEL_RS2, BR_COND, F3_BLT);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        n_cmp++; if ({redirect_valid, out_dnpc, out_result} !== {1'b1, 32'h8000_0140, 32'd1}) begin n_err++; $display("FAIL blt_taken: got rv=%b dnpc=%h res=%h want 1 80000140 00000001", redirect_valid, out_dnpc, out_result); end
        set_op(32'h8000_0100, 32'hFFFF_FFFF, 32'd1, 32'h40, ALU_SLTU, 1'b0, BSEL_RS2, BR_COND, F3_BLTU);
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({redirect_valid, out_dnpc, out_result} !== {1'b0, 32'h8000_0104, 32'd0}) begin n_err++; $display("FAIL bltu_not_taken: got rv=%b dnpc=%h res=%h want 0 80000104 00000000", redirect_valid, out_dnpc, out_result); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bltu_valid: got %b want 1", out_valid); end
        tick();
    endtask

    task automatic test_jalr();
        set_op(32'h8000_0000, 32'h8000_0101, 32'h0, 32'd4, ALU_ADD, 1'b1, BSEL_FOUR, BR_JALR, 3'b000);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_result !== 32'h8000_0004) begin n_err++; $display("FAIL jalr_link: got %h want 80000004", out_result); end
        n_cmp++; if ({redirect_valid, redirect_pc, out_dnpc} !== {1'b1, 32'h8000_0104, 32'h8000_0104}) begin n_err++; $display("FAIL jalr_target: got rv=%b rpc=%h dnpc=%h want 1 80000104 80000104", redirect_valid, redirect_pc, out_dnpc); end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        set_op(32'h8000_0300, 32'h10, 32'h10, 32'h20, ALU_SUB, 1'b0, BSEL_RS2, BR_COND, F3_BEQ);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        if (redirect_valid === 1'b1) pulses++;
        set_op(32'h8000_0400, 32'd0, 32'd100, 32'h0, ALU_ADD, 1'b0, BSEL_RS2, BR_NONE, 3'b000);
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
            tick();
            if (redirect_valid === 1'b1) pulses++;
            n_cmp++; if ({out_valid, out_result, out_dnpc, out_pc} !== {1'b1, 32'd0, 32'h8000_0320, 32'h8000_0300}) begin n_err++; $display("FAIL stall_hold[%0d]: got v=%b res=%h dnpc=%h pc=%h", c, out_valid, out_result, out_dnpc, out_pc); end
        end
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_rs1 = k;
            tick();
            n_cmp++; if ({out_valid, out_result} !== {1'b1, 32'd100 + 32'(k)}) begin n_err++; $display("FAIL stream[%0d]: got v=%b res=%h want 1 %h", k, out_valid, out_result, 32'd100 + 32'(k)); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_jal_odd();
        set_op(32'h8000_0000, 32'h0, 32'h0, 32'd6, ALU_ADD, 1'b1, BSEL_FOUR, BR_JAL, 3'b000);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_result, out_dnpc} !== {32'h8000_0004, 32'h8000_0006}) begin n_err++; $display("FAIL jal_odd_data: got res=%h dnpc=%h want 80000004 80000006", out_result, out_dnpc); end
`ifdef YSYX_24100027_EXU_MISALIGN_EN
        n_cmp++; if ({out_exc, redirect_valid} !== 2'b10) begin n_err++; $display("FAIL jal_misalign: got exc=%b rv=%b want 1 0", out_exc, redirect_valid); end
`else
        n_cmp++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_0006}) begin n_err++; $display("FAIL jal_redirect: got rv=%b rpc=%h want 1 80000006", redirect_valid, redirect_pc); end
`endif
    endtask

    task automatic test_reset_full();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_before_reset: got %b want 1", out_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if ({out_valid, redirect_valid, out_wen, out_result, out_dnpc} !== 67'h0) begin n_err++; $display("FAIL reset_full: got v=%b rv=%b wen=%b res=%h dnpc=%h want 0", out_valid, redirect_valid, out_wen, out_result, out_dnpc); end
`ifdef YSYX_24100027_EXU_MISALIGN_EN
        n_cmp++; if (out_exc !== 1'b0) begin n_err++; $display("FAIL reset_exc: got %b want 0", out_exc); end
`endif
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(32'h0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1'b0, BSEL_RS2, BR_NONE, 3'b000);
        test_reset();
        test_add();
        test_beq();
        test_blt();
        test_jalr();
        test_back_to_back();
        test_jal_odd();
        test_reset_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
